ps2_keyboard_decoder: RTL and testbench

PS2_KEYBOARD_DECODER -- requirements
Module: ps2_keyboard_decoder

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_frame_rx.sv | 123 ++++++++++++
 rtl/ps2_keyboard_decoder.sv | 102 ++++++++++
 tb/tb_ps2_keyboard_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM state type for the PS/2 keyboard decoder.
package ps2_pkg;

    // Scancode prefix bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Frame receiver states: start bit is consumed in StIdle
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

endpackage : ps2_pkg

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw pins, detects ps2_clk falling
// edges, assembles 11-bit frames and flags parity, stop-bit and timeout errors.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic            clk_s1_q, clk_s2_q, clk_hist_q;
    logic            data_s1_q, data_s2_q;
    ps2_state_e      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [CntW-1:0] tcnt_q, tcnt_d;
    logic            fall;
    logic            timeout;

    // Two-flop synchronizers plus history flop on ps2_clk; idle-high on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_hist_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_hist_q <= clk_s2_q;
            data_s1_q  <= ps2_data_i;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fall    = ~clk_s2_q & clk_hist_q;
    assign timeout = (state_q != StIdle) && !fall && (tcnt_q == CntLast);

    // Frame FSM and timeout counter next-state; strobes are combinational so
    // the top can register them on the same edge that consumes the stop bit
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tcnt_d       = tcnt_q;
        byte_valid_o = 1'b0;
        err_o        = 1'b0;

        if (state_q == StIdle || fall) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (timeout) begin
            state_d = StIdle;
            tcnt_d  = '0;
            err_o   = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = data_s2_q;
                    state_d  = StStop;
                end
                StStop: begin
                    // Odd parity: data plus parity bit carry an odd number of ones
                    if (data_s2_q && (^{shift_q, parity_q})) begin
                        byte_valid_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Frame FSM, shift register and timeout counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign byte_o = shift_q;

endmodule : ps2_frame_rx

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard scancode decoder: folds E0/F0 prefixes into a held
// keycode/make/ext triple with a one-cycle valid strobe.
module ps2_keyboard_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic [7:0] keycode_q, keycode_d;
    logic       make_q, make_d;
    logic       ext_q, ext_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i       (clk),
        .rst_ni      (reset),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .err_o       (rx_err)
    );

    // Prefix tracking and output triple next-state
    always_comb begin
        keycode_d  = keycode_q;
        make_d     = make_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;

        if (rx_err) begin
            // A broken frame may have eaten a code, so pending prefixes are stale
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (rx_valid) begin
            case (rx_byte)
                PS2_EXT:   ext_pend_d = 1'b1;
                PS2_BRK:   brk_pend_d = 1'b1;
                PS2_PAUSE: ;
                default: begin
                    keycode_d  = rx_byte;
                    make_d     = ~brk_pend_q;
                    ext_d      = ext_pend_q;
                    valid_d    = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            endcase
        end
    end

    // Output and prefix flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keycode_q  <= 8'h00;
            make_q     <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            keycode_q  <= keycode_d;
            make_q     <= make_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_make  = make_q;
    assign key_ext   = ext_q;
    assign key_valid = valid_q;
    assign frame_err = err_q;

endmodule : ps2_keyboard_decoder

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: directed scancode sequences
// followed by randomized frames, checked against a scancode-level model.
module tb_ps2_keyboard_decoder;
    import ps2_pkg::*;

    localparam int unsigned TO = 200;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_make;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Monitor tallies
    int mon_valid = 0;
    int mon_err   = 0;
    int excl_viol = 0;

    // Scancode-level model state
    bit       m_ext_pend = 0;
    bit       m_brk_pend = 0;
    bit [7:0] m_key  = 8'h00;
    bit       m_make = 0;
    bit       m_kext = 0;
    int       m_nvalid = 0;
    int       m_nerr   = 0;
    bit       exp_valid, exp_err;

    ps2_keyboard_decoder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .key_make (key_make),
        .key_ext  (key_ext),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes away from the active edge
    always @(negedge clk) begin
        if (key_valid) mon_valid++;
        if (frame_err) mon_err++;
        if (key_valid && frame_err) excl_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: what a whole received frame means at scancode level
    task automatic model_frame(input bit [7:0] b, input bit good);
        exp_valid = 0;
        exp_err   = 0;
        if (!good) begin
            exp_err = 1;
            m_nerr++;
            m_ext_pend = 0;
            m_brk_pend = 0;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1;
        end else if (b != 8'hE1) begin
            exp_valid = 1;
            m_nvalid++;
            m_key  = b;
            m_make = !m_brk_pend;
            m_kext = m_ext_pend;
            m_ext_pend = 0;
            m_brk_pend = 0;
        end
    endtask

    task automatic model_reset();
        m_ext_pend = 0;
        m_brk_pend = 0;
        m_key  = 8'h00;
        m_make = 0;
        m_kext = 0;
    endtask

    // One PS/2 bit cell, period about 30 clk cycles
    task automatic ps2_pulse(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (15) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input string tag);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_pulse(1'b0);
        for (int i = 0; i < 8; i++) ps2_pulse(b[i]);
        ps2_pulse(par);
        @(negedge clk);
        ps2_data = ~bad_stop;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        model_frame(b, !(bad_par || bad_stop));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_valid_lat"}, 32'(key_valid), 32'(exp_valid));
        check({tag, "_err_lat"}, 32'(frame_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "_strobe_one"}, {30'd0, key_valid, frame_err}, 32'd0);
        repeat (12) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        check({tag, "_keycode"}, 32'(keycode), 32'(m_key));
        check({tag, "_make"}, 32'(key_make), 32'(m_make));
        check({tag, "_ext"}, 32'(key_ext), 32'(m_kext));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_keycode"}, 32'(keycode), 32'h00);
        check({tag, "_flags"}, {28'd0, key_make, key_ext, key_valid, frame_err}, 32'd0);
        check({tag, "_state"}, 32'(dut.u_rx.state_q), 32'(StIdle));
    endtask

    initial begin
        bit       got;
        bit [7:0] rb;
        int       sel;

        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Plain make, break, extended break, extended-then-plain
        send_frame(8'h1C, 0, 0, "make_1c");
        send_frame(8'hF0, 0, 0, "brk_pre");
        send_frame(8'h1C, 0, 0, "brk_1c");
        send_frame(8'hE0, 0, 0, "ext_pre");
        send_frame(8'hF0, 0, 0, "ext_brk_pre");
        send_frame(8'h75, 0, 0, "ext_brk_75");
        send_frame(8'h75, 0, 0, "plain_75");

        // Parity error clears prefixes; pending F0 must be forgotten
        send_frame(8'hF0, 0, 0, "pre_before_perr");
        send_frame(8'h1C, 1, 0, "perr_1c");
        send_frame(8'hE0, 0, 0, "after_perr_e0");
        send_frame(8'h1C, 0, 0, "after_perr_1c");

        // Stop-bit error, pause prefix drop, repeated prefix
        send_frame(8'hE0, 0, 0, "pre_before_serr");
        send_frame(8'h3A, 0, 1, "serr_3a");
        send_frame(8'hE1, 0, 0, "pause");
        send_frame(8'hE0, 0, 0, "rep_e0_a");
        send_frame(8'hE0, 0, 0, "rep_e0_b");
        send_frame(8'h6C, 0, 0, "rep_e0_6c");

        // Timeout mid-frame after start and 3 data bits
        send_frame(8'hE0, 0, 0, "pre_before_to");
        ps2_pulse(1'b0);
        ps2_pulse(1'b1);
        ps2_pulse(1'b0);
        ps2_pulse(1'b1);
        got = 0;
        for (int i = 0; i < int'(TO) + 60; i++) begin
            @(negedge clk);
            if (frame_err) begin
                got = 1;
                break;
            end
        end
        check("timeout_err", 32'(got), 32'd1);
        check("timeout_no_valid", 32'(key_valid), 32'd0);
        check("timeout_state", 32'(dut.u_rx.state_q), 32'(StIdle));
        model_frame(8'h00, 0);
        repeat (5) @(negedge clk);
        send_frame(8'h29, 0, 0, "after_to_29");

        // Reset mid-frame with a pending E0
        send_frame(8'hE0, 0, 0, "pre_before_rst");
        ps2_pulse(1'b0);
        ps2_pulse(1'b1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h6B, 0, 0, "after_rst_6b");

        // Randomized frame stream
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: rb = 8'hE1;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            send_frame(rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0), "rnd");
        end

        check("total_valid", 32'(mon_valid), 32'(m_nvalid));
        check("total_err", 32'(mon_err), 32'(m_nerr));
        check("valid_err_excl", 32'(excl_viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_ps2_keyboard_decoder
